// File: rtl/tron_pkg.sv
// Shared types and constants for the trail writer/reader pair.
package tron_pkg;

  // Bike heading as carried on the Blue_dir/Red_dir buses.
  typedef enum logic [1:0] {
    DIR_DOWN  = 2'b00,
    DIR_UP    = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_e;

  localparam logic [2:0] GAME_PLAYING = 3'b010;

  // Probe offsets from the bike origin to the cell just ahead of its nose.
  localparam int OFS_VERT_X  = 8;
  localparam int OFS_DOWN_Y  = 9;
  localparam int OFS_UP_Y    = -9;
  localparam int OFS_RIGHT_X = 17;
  localparam int OFS_LEFT_X  = -2;

  localparam int ROW_WORDS = 320;
  localparam int ADDR_W    = 20;

  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    BIKE_BLUE = 1'b0,
    BIKE_RED  = 1'b1
  } bike_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4
  } rd_state_e;

endpackage

// File: rtl/trail_collision_reader_if.sv
// Frame-buffer read port shared with the trail writer through an arbiter.
//
// Handshake: the master holds rd_req high with a stable rd_addr until the
// arbiter answers with rd_gnt. A read issues on exactly those cycles where
// rd_req && rd_gnt are both high; rd_data for that read is valid RD_LAT
// cycles later and carries no valid flag of its own. rd_addr is 0 whenever
// rd_req is low.
interface trail_collision_reader_if;
  import tron_pkg::*;

  logic      rd_req;
  logic      rd_gnt;
  fb_addr_t  rd_addr;
  logic [15:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_gnt, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_gnt, output rd_data);
endinterface

// File: rtl/probe_addr_calc.sv
// Maps one bike position/heading to the frame-buffer word of its probe cell
// and flags probes that fall outside the play area.
module probe_addr_calc
  import tron_pkg::*;
#(
  parameter int X_MIN = 0,
  parameter int X_MAX = 151,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 223
) (
  input  logic [7:0] pos_x,
  input  logic [7:0] pos_y,
  input  logic [1:0] dir,
  output fb_addr_t   addr,
  output logic       oob
);

  logic signed [9:0] px;
  logic signed [9:0] py;
  logic [9:0]        px_u;
  logic [9:0]        py_u;

  // Step one cell ahead of the nose in signed space, bounds-check, then address.
  always_comb begin
    px = signed'({2'b00, pos_x});
    py = signed'({2'b00, pos_y});
    case (dir_e'(dir))
      DIR_DOWN:  begin px = px + 10'(OFS_VERT_X); py = py + 10'(OFS_DOWN_Y); end
      DIR_UP:    begin px = px + 10'(OFS_VERT_X); py = py + 10'(OFS_UP_Y);   end
      DIR_RIGHT: begin px = px + 10'(OFS_RIGHT_X); end
      DIR_LEFT:  begin px = px + 10'(OFS_LEFT_X);  end
      default:   begin px = px; end
    endcase
    oob  = (px < 10'(X_MIN)) || (px > 10'(X_MAX)) ||
           (py < 10'(Y_MIN)) || (py > 10'(Y_MAX));
    px_u = px;
    py_u = py;
    // Two words per bike unit horizontally, four pixel rows per bike unit vertically.
    addr = (fb_addr_t'(px_u) << 1) + fb_addr_t'(py_u) * fb_addr_t'(ROW_WORDS * 4);
  end

endmodule

// File: rtl/trail_collision_reader.sv
// Once per frame, reads the 2x2 cell ahead of each bike and reports crashes.
module trail_collision_reader
  import tron_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int X_MIN  = 0,
  parameter int X_MAX  = 151,
  parameter int Y_MIN  = 0,
  parameter int Y_MAX  = 223
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] Game_State,
  input  logic [7:0] Blue_X,
  input  logic [7:0] Blue_Y,
  input  logic [7:0] Red_X,
  input  logic [7:0] Red_Y,
  input  logic [1:0] Blue_dir,
  input  logic [1:0] Red_dir,
  trail_collision_reader_if.master rd_bus,
  output logic       blue_hit,
  output logic       red_hit,
  output logic       hit_valid,
  output logic       draw,
  output rd_state_e  dbg_state
);

  rd_state_e state, state_nxt;
  logic      playing, frame_d, start;
  fb_addr_t  blue_addr, red_addr;
  logic      blue_oob, red_oob;
  fb_addr_t  cand_addr [4];
  bike_e     cand_bike [4];
  logic [2:0] cand_cnt;
  fb_addr_t  list_addr [4];
  bike_e     list_bike [4];
  logic [2:0] list_cnt;
  logic [1:0] list_idx;
  logic [RD_LAT-1:0] tag_vld;
  bike_e     tag_bike [RD_LAT];
  logic      issue, req, scan_blue, scan_red;
  fb_addr_t  addr;

  assign playing   = (Game_State == GAME_PLAYING);
  assign start     = frame_clk && !frame_d && playing;
  assign dbg_state = state;
  assign rd_bus.rd_req  = req;
  assign rd_bus.rd_addr = addr;

  probe_addr_calc #(.X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) u_blue_probe (
    .pos_x(Blue_X), .pos_y(Blue_Y), .dir(Blue_dir), .addr(blue_addr), .oob(blue_oob)
  );

  probe_addr_calc #(.X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)) u_red_probe (
    .pos_x(Red_X), .pos_y(Red_Y), .dir(Red_dir), .addr(red_addr), .oob(red_oob)
  );

  // Pack the in-bounds bikes' two row reads into a dense list, blue first.
  always_comb begin
    cand_cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cand_addr[i] = '0;
      cand_bike[i] = BIKE_BLUE;
    end
    if (!blue_oob) begin
      cand_addr[0] = blue_addr;
      cand_addr[1] = blue_addr + fb_addr_t'(ROW_WORDS);
      cand_cnt     = 3'd2;
    end
    if (!red_oob) begin
      if (!blue_oob) begin
        cand_addr[2] = red_addr;
        cand_addr[3] = red_addr + fb_addr_t'(ROW_WORDS);
        cand_bike[2] = BIKE_RED;
        cand_bike[3] = BIKE_RED;
      end else begin
        cand_addr[0] = red_addr;
        cand_addr[1] = red_addr + fb_addr_t'(ROW_WORDS);
        cand_bike[0] = BIKE_RED;
        cand_bike[1] = BIKE_RED;
      end
      cand_cnt = cand_cnt + 3'd2;
    end
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state and read-port drive; leaving play aborts from any state.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    addr      = '0;
    issue     = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_CALC;
      ST_CALC:   state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (list_cnt == 3'd0) begin
          state_nxt = ST_DRAIN;
        end else begin
          req  = 1'b1;
          addr = list_addr[list_idx];
          if (rd_bus.rd_gnt) begin
            issue = 1'b1;
            if ({1'b0, list_idx} + 3'd1 == list_cnt) state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN:  if (tag_vld == '0) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (!playing) begin
      state_nxt = ST_IDLE;
      req       = 1'b0;
      addr      = '0;
      issue     = 1'b0;
    end
  end

  // Frame strobe history for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) frame_d <= 1'b0;
    else       frame_d <= frame_clk;
  end

  // Issue list: loaded in CALC, walked one entry per granted read.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) begin
        list_addr[i] <= '0;
        list_bike[i] <= BIKE_BLUE;
      end
      list_cnt <= 3'd0;
      list_idx <= 2'd0;
    end else if (state == ST_CALC) begin
      list_addr <= cand_addr;
      list_bike <= cand_bike;
      list_cnt  <= cand_cnt;
      list_idx  <= 2'd0;
    end else if (issue) begin
      list_idx <= list_idx + 2'd1;
    end
  end

  // Return tags ride alongside the memory latency; flushed when play stops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tag_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_bike[i] <= BIKE_BLUE;
    end else if (!playing) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0]  <= issue;
      tag_bike[0] <= list_bike[list_idx];
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_bike[i] <= tag_bike[i-1];
      end
    end
  end

  // Per-scan results: seeded with the wall hits, then any nonzero word returned.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scan_blue <= 1'b0;
      scan_red  <= 1'b0;
    end else if (state == ST_CALC) begin
      scan_blue <= blue_oob;
      scan_red  <= red_oob;
    end else if (tag_vld[RD_LAT-1] && (rd_bus.rd_data != 16'h0)) begin
      if (tag_bike[RD_LAT-1] == BIKE_BLUE) scan_blue <= 1'b1;
      else                                 scan_red  <= 1'b1;
    end
  end

  // Sticky crash flags and the scan-complete pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blue_hit  <= 1'b0;
      red_hit   <= 1'b0;
      draw      <= 1'b0;
      hit_valid <= 1'b0;
    end else if (!playing) begin
      blue_hit  <= 1'b0;
      red_hit   <= 1'b0;
      draw      <= 1'b0;
      hit_valid <= 1'b0;
    end else begin
      hit_valid <= (state == ST_REPORT);
      if (state == ST_REPORT) begin
        blue_hit <= blue_hit | scan_blue;
        red_hit  <= red_hit | scan_red;
        draw     <= draw | (scan_blue & scan_red);
      end
    end
  end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Bench for trail_collision_reader: sparse frame-buffer model behind the read
// port, and a scan-level reference model of probes, reads and sticky flags.
module tb_trail_collision_reader;
  import tron_pkg::*;

  localparam int RD_LAT = 2;
  localparam int XMIN = 0, XMAX = 151, YMIN = 0, YMAX = 223;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [2:0] Game_State = GAME_PLAYING;
  logic [7:0] Blue_X = '0, Blue_Y = '0, Red_X = '0, Red_Y = '0;
  logic [1:0] Blue_dir = '0, Red_dir = '0;
  logic       blue_hit, red_hit, hit_valid, draw;
  rd_state_e  dbg_state;

  trail_collision_reader_if bus ();

  trail_collision_reader #(.RD_LAT(RD_LAT), .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .Blue_dir(Blue_dir), .Red_dir(Red_dir), .rd_bus(bus),
    .blue_hit(blue_hit), .red_hit(red_hit), .hit_valid(hit_valid), .draw(draw),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #10 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;

  logic [15:0] mem [int];
  logic [19:0] exp_q [$];
  logic [19:0] obs_q [$];
  int hv_count = 0;
  int addr_idle_err = 0;
  int cyc = 0;
  int gnt_mode = 0;
  int stall_start = 0;
  int obs0, hv0;
  bit m_blue, m_red, m_draw;

  logic [15:0] rpipe_d [RD_LAT];
  bit          rpipe_v [RD_LAT];

  function automatic logic [15:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'h0;
  endfunction

  // Frame-buffer port model: arbiter grant policy plus fixed-latency memory.
  always @(negedge Clk) begin
    cyc++;
    bus.rd_data = rpipe_v[RD_LAT-1] ? rpipe_d[RD_LAT-1] : 16'($urandom_range(1, 65535));
    for (int i = RD_LAT - 1; i > 0; i--) begin
      rpipe_v[i] = rpipe_v[i-1];
      rpipe_d[i] = rpipe_d[i-1];
    end
    case (gnt_mode)
      0: bus.rd_gnt = 1'b1;
      1: bus.rd_gnt = 1'($urandom_range(0, 1));
      default: bus.rd_gnt = (cyc - stall_start < 7) ? 1'b0 : 1'(cyc & 1);
    endcase
    #1;
    if (bus.rd_req === 1'b1 && bus.rd_gnt === 1'b1) begin
      rpipe_v[0] = 1'b1;
      rpipe_d[0] = mem_rd(int'(bus.rd_addr));
      obs_q.push_back(bus.rd_addr);
    end else begin
      rpipe_v[0] = 1'b0;
    end
    if (bus.rd_req !== 1'b1 && bus.rd_addr !== 20'h0) addr_idle_err++;
    if (hit_valid === 1'b1) hv_count++;
  end

  // ---------------- reference model ----------------
  function automatic void model_probe(input int x, input int y, input int d, output int px, output int py);
    case (d)
      0:       begin px = x + 8;  py = y + 9; end
      1:       begin px = x + 8;  py = y - 9; end
      2:       begin px = x + 17; py = y;     end
      default: begin px = x - 2;  py = y;     end
    endcase
  endfunction

  function automatic bit model_bike(input int x, input int y, input int d);
    int px, py, base;
    bit hit;
    model_probe(x, y, d, px, py);
    if (px < XMIN || px > XMAX || py < YMIN || py > YMAX) return 1'b1;
    base = px * 2 + py * 1280;
    hit = 1'b0;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(20'(base + r * 320));
      if (mem_rd(base + r * 320) != 16'h0) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic void model_scan(input int bx, input int by, input int bd, input int rx, input int ry, input int rdir);
    bit sb, sr;
    exp_q.delete();
    sb = model_bike(bx, by, bd);
    sr = model_bike(rx, ry, rdir);
    m_blue = m_blue | sb;
    m_red  = m_red | sr;
    m_draw = m_draw | (sb & sr);
  endfunction

  function automatic bit reads_ok();
    if (obs_q.size() - obs0 != exp_q.size()) return 1'b0;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[obs0 + i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_bikes(input int bx, input int by, input int bd, input int rx, input int ry, input int rdir);
    Blue_X = 8'(bx); Blue_Y = 8'(by); Blue_dir = 2'(bd);
    Red_X  = 8'(rx); Red_Y  = 8'(ry); Red_dir  = 2'(rdir);
  endtask

  task automatic pulse_frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
  endtask

  task automatic wait_pulse(output bit to);
    int n;
    n = 0;
    while (hv_count == hv0 && n < 300) begin
      @(negedge Clk);
      n++;
    end
    to = (hv_count == hv0);
  endtask

  task automatic run_scan(input int bx, input int by, input int bd, input int rx, input int ry,
                          input int rdir, input int mode, output bit to);
    @(negedge Clk);
    set_bikes(bx, by, bd, rx, ry, rdir);
    gnt_mode = mode;
    stall_start = cyc;
    model_scan(bx, by, bd, rx, ry, rdir);
    obs0 = obs_q.size();
    hv0 = hv_count;
    pulse_frame();
    wait_pulse(to);
    repeat (4) @(negedge Clk);
  endtask

  task automatic drop_game();
    @(negedge Clk) Game_State = 3'b000;
    repeat (2) @(negedge Clk);
    Game_State = GAME_PLAYING;
    m_blue = 1'b0; m_red = 1'b0; m_draw = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    #2;
    checks++;
    if ({blue_hit, red_hit, draw, hit_valid, bus.rd_req} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b want 00000", {blue_hit, red_hit, draw, hit_valid, bus.rd_req});
    end
    checks++;
    if (bus.rd_addr !== 20'h0) begin failures++; $display("FAIL reset_addr: got %0d want 0", bus.rd_addr); end
    checks++;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    @(negedge Clk) Reset = 1'b0;
    m_blue = 1'b0; m_red = 1'b0; m_draw = 1'b0;
  endtask

  task automatic test_clean_scan();
    bit to;
    logic [19:0] spec_addr [4];
    spec_addr[0] = 20'd38474; spec_addr[1] = 20'd38794; spec_addr[2] = 20'd52696; spec_addr[3] = 20'd53016;
    mem.delete();
    run_scan(20, 30, 2, 100, 50, 1, 0, to);
    checks++;
    if (to) begin failures++; $display("FAIL clean_timeout: no hit_valid within 300 cycles"); end
    checks++;
    if (hv_count - hv0 != 1) begin failures++; $display("FAIL clean_pulses: got %0d want 1", hv_count - hv0); end
    checks++;
    if (reads_ok() !== 1'b1) begin failures++; $display("FAIL clean_reads: got %0d reads want %0d", obs_q.size() - obs0, exp_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q.size() <= obs0 + i || obs_q[obs0 + i] !== spec_addr[i]) begin
        failures++; $display("FAIL clean_addr%0d: got %0d want %0d", i, (obs_q.size() > obs0 + i) ? obs_q[obs0 + i] : 20'hFFFFF, spec_addr[i]);
      end
    end
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b000) begin failures++; $display("FAIL clean_flags: got %b want 000", {blue_hit, red_hit, draw}); end
    checks++;
    if (addr_idle_err != 0) begin failures++; $display("FAIL idle_addr: got %0d nonzero idle addresses want 0", addr_idle_err); end
  endtask

  task automatic test_blue_hit();
    bit to;
    mem.delete();
    mem[38794] = 16'h0001;
    mem[38475] = 16'h00FF;
    run_scan(20, 30, 2, 100, 50, 1, 0, to);
    checks++;
    if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL blue_pulse: got %0d pulses want 1", hv_count - hv0); end
    checks++;
    if ({blue_hit, red_hit, draw} !== {m_blue, m_red, m_draw}) begin
      failures++; $display("FAIL blue_flags: got %b want %b", {blue_hit, red_hit, draw}, {m_blue, m_red, m_draw});
    end
    mem.delete();
    run_scan(20, 30, 2, 100, 50, 1, 0, to);
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b100) begin failures++; $display("FAIL blue_sticky: got %b want 100", {blue_hit, red_hit, draw}); end
  endtask

  task automatic test_oob();
    bit to;
    drop_game();
    mem.delete();
    run_scan(1, 40, 3, 100, 50, 1, 0, to);
    checks++;
    if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL oob1_pulse: got %0d pulses want 1", hv_count - hv0); end
    checks++;
    if (reads_ok() !== 1'b1 || obs_q.size() - obs0 != 2) begin failures++; $display("FAIL oob1_reads: got %0d reads want 2", obs_q.size() - obs0); end
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b100) begin failures++; $display("FAIL oob1_flags: got %b want 100", {blue_hit, red_hit, draw}); end
    run_scan(1, 40, 3, 150, 60, 2, 0, to);
    checks++;
    if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL oob2_pulse: got %0d pulses want 1", hv_count - hv0); end
    checks++;
    if (obs_q.size() - obs0 != 0) begin failures++; $display("FAIL oob2_reads: got %0d reads want 0", obs_q.size() - obs0); end
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b111) begin failures++; $display("FAIL oob2_flags: got %b want 111", {blue_hit, red_hit, draw}); end
  endtask

  task automatic test_stall();
    bit to;
    drop_game();
    mem.delete();
    mem[53016] = 16'h0005;
    run_scan(20, 30, 2, 100, 50, 1, 2, to);
    checks++;
    if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL stall_pulse: got %0d pulses want 1", hv_count - hv0); end
    checks++;
    if (reads_ok() !== 1'b1) begin failures++; $display("FAIL stall_reads: got %0d reads want %0d", obs_q.size() - obs0, exp_q.size()); end
    checks++;
    if ({blue_hit, red_hit, draw} !== {m_blue, m_red, m_draw}) begin
      failures++; $display("FAIL stall_flags: got %b want %b", {blue_hit, red_hit, draw}, {m_blue, m_red, m_draw});
    end
  endtask

  task automatic test_abort();
    bit to;
    int n;
    mem.delete();
    mem[38474] = 16'h8000;
    run_scan(20, 30, 2, 100, 50, 1, 0, to);
    checks++;
    if (blue_hit !== 1'b1) begin failures++; $display("FAIL abort_pre: got blue_hit=%b want 1", blue_hit); end
    @(negedge Clk);
    hv0 = hv_count;
    pulse_frame();
    n = 0;
    while (dbg_state !== ST_DRAIN && n < 50) begin @(negedge Clk); n++; end
    checks++;
    if (dbg_state !== ST_DRAIN) begin failures++; $display("FAIL abort_drain: got state %0d want DRAIN", dbg_state); end
    Game_State = 3'b000;
    m_blue = 1'b0; m_red = 1'b0; m_draw = 1'b0;
    @(negedge Clk);
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b000 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL abort_clear: got flags %b state %0d want 000 IDLE", {blue_hit, red_hit, draw}, dbg_state);
    end
    repeat (10) @(negedge Clk);
    checks++;
    if (hv_count != hv0) begin failures++; $display("FAIL abort_pulse: got %0d pulses want 0", hv_count - hv0); end
    Game_State = GAME_PLAYING;
    mem.delete();
    run_scan(20, 30, 2, 100, 50, 1, 0, to);
    checks++;
    if (to || hv_count - hv0 != 1 || reads_ok() !== 1'b1) begin
      failures++; $display("FAIL abort_rescan: got %0d pulses %0d reads want 1 4", hv_count - hv0, obs_q.size() - obs0);
    end
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b000) begin failures++; $display("FAIL abort_rescan_flags: got %b want 000", {blue_hit, red_hit, draw}); end
  endtask

  task automatic test_double_edge();
    bit to;
    mem.delete();
    @(negedge Clk);
    set_bikes(20, 30, 2, 100, 50, 1);
    gnt_mode = 0;
    model_scan(20, 30, 2, 100, 50, 1);
    obs0 = obs_q.size();
    hv0 = hv_count;
    pulse_frame();
    @(negedge Clk);
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    wait_pulse(to);
    repeat (30) @(negedge Clk);
    checks++;
    if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL double_pulses: got %0d want 1", hv_count - hv0); end
    checks++;
    if (reads_ok() !== 1'b1) begin failures++; $display("FAIL double_reads: got %0d reads want %0d", obs_q.size() - obs0, exp_q.size()); end
  endtask

  task automatic test_random();
    bit to;
    int bx, by, bd, rx, ry, rdir, px, py, base;
    int offs [4];
    offs[0] = 0; offs[1] = 320; offs[2] = 1; offs[3] = 640;
    for (int it = 0; it < 10; it++) begin
      drop_game();
      checks++;
      if ({blue_hit, red_hit, draw} !== 3'b000) begin failures++; $display("FAIL rand%0d_clear: got %b want 000", it, {blue_hit, red_hit, draw}); end
      bx = $urandom_range(0, 165); by = $urandom_range(0, 235); bd = $urandom_range(0, 3);
      rx = $urandom_range(0, 165); ry = $urandom_range(0, 235); rdir = $urandom_range(0, 3);
      mem.delete();
      for (int b = 0; b < 2; b++) begin
        if (b == 0) model_probe(bx, by, bd, px, py);
        else        model_probe(rx, ry, rdir, px, py);
        base = px * 2 + py * 1280;
        for (int k = 0; k < 4; k++)
          if ($urandom_range(0, 3) == 0) mem[base + offs[k]] = 16'($urandom_range(1, 65535));
      end
      run_scan(bx, by, bd, rx, ry, rdir, 1, to);
      checks++;
      if (to || hv_count - hv0 != 1) begin failures++; $display("FAIL rand%0d_pulse: got %0d want 1", it, hv_count - hv0); end
      checks++;
      if (reads_ok() !== 1'b1) begin failures++; $display("FAIL rand%0d_reads: got %0d reads want %0d", it, obs_q.size() - obs0, exp_q.size()); end
      checks++;
      if ({blue_hit, red_hit, draw} !== {m_blue, m_red, m_draw}) begin
        failures++; $display("FAIL rand%0d_flags: got %b want %b", it, {blue_hit, red_hit, draw}, {m_blue, m_red, m_draw});
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit to;
    int n;
    run_scan(1, 40, 3, 150, 60, 2, 0, to);
    checks++;
    if ({blue_hit, red_hit, draw} !== 3'b111) begin failures++; $display("FAIL midrst_pre: got %b want 111", {blue_hit, red_hit, draw}); end
    @(negedge Clk);
    set_bikes(20, 30, 2, 100, 50, 1);
    gnt_mode = 2;
    stall_start = cyc;
    hv0 = hv_count;
    pulse_frame();
    n = 0;
    while (dbg_state !== ST_ISSUE && n < 20) begin @(negedge Clk); n++; end
    Reset = 1'b1;
    #1;
    checks++;
    if ({blue_hit, red_hit, draw, hit_valid, bus.rd_req} !== 5'b0 || dbg_state !== ST_IDLE) begin
      failures++; $display("FAIL midrst_clear: got %b state %0d want 00000 IDLE", {blue_hit, red_hit, draw, hit_valid, bus.rd_req}, dbg_state);
    end
    @(negedge Clk) Reset = 1'b0;
    repeat (20) @(negedge Clk);
    checks++;
    if (hv_count != hv0) begin failures++; $display("FAIL midrst_pulse: got %0d pulses want 0", hv_count - hv0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < RD_LAT; i++) begin rpipe_v[i] = 1'b0; rpipe_d[i] = 16'h0; end
    bus.rd_gnt = 1'b0;
    bus.rd_data = 16'h0;
    test_reset();
    test_clean_scan();
    test_blue_hit();
    test_oob();
    test_stall();
    test_abort();
    test_double_edge();
    test_random();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trail_collision_reader.md
Name: trail_collision_reader

Overview:
- Read-side companion to the trail writer: once per frame it probes the frame buffer one cell ahead of each bike and reports blue/red crashes to the game-state controller.
- Shares the frame-buffer port with the trail writer through an external arbiter, using a req/gnt handshake.
- Any nonzero word at a probe address is a crash; a probe outside the play area is a wall crash.

Parameters:
- RD_LAT, 2, cycles from granted read to valid rd_data
- ROW_WORDS, 320, frame-buffer words per pixel row
- X_MIN, 0, lowest legal probe X in bike units
- X_MAX, 151, highest legal probe X
- Y_MIN, 0, lowest legal probe Y
- Y_MAX, 223, highest legal probe Y

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  frame strobe (~60 Hz), synchronous to Clk
- Game_State  in  3  3'b010 = playing
- Blue_X, Blue_Y, Red_X, Red_Y  in  8 each  bike positions in bike units
- Blue_dir, Red_dir  in  2 each  00 down, 01 up, 10 right, 11 left
- rd_req  out  1  read request
- rd_gnt  in  1  arbiter grant; a read issues on a cycle with rd_req && rd_gnt
- rd_addr  out  20  frame-buffer word address
- rd_data  in  16  read data, valid RD_LAT cycles after issue
- blue_hit, red_hit  out  1 each  sticky crash flags
- hit_valid  out  1  one-cycle pulse when a scan completes
- draw  out  1  both bikes hit in the same scan (sticky)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, pipeline tags cleared.
- Start condition: rising edge of frame_clk (registered compare) while Game_State == 3'b010. Edges that arrive while the FSM is not in IDLE are dropped.
- Probe point, computed in 10-bit signed arithmetic from the bike position:
  - dir 00 (down): (X+8, Y+9)
  - dir 01 (up): (X+8, Y-9)
  - dir 10 (right): (X+17, Y)
  - dir 11 (left): (X-2, Y)
- Out-of-bounds probe: if px < X_MIN, px > X_MAX, py < Y_MIN or py > Y_MAX, that bike is flagged a hit immediately and issues no reads.
- Address: base = px*2 + py*ROW_WORDS*4, truncated to 20 bits. Each in-bounds bike issues 2 reads, base and base+ROW_WORDS, which are the two rows of its 2x2 cell.
- FSM states:
  - IDLE: go to CALC on a start condition.
  - CALC: one cycle; register the probe addresses and OOB flags, build an issue list of 0-4 entries (blue first), go to ISSUE.
  - ISSUE: hold rd_req=1 with the current address. Advance only on rd_gnt. When the list is empty (including an initially empty list), go to DRAIN.
  - DRAIN: wait until every outstanding read has returned, then go to REPORT.
  - REPORT: one cycle; pulse hit_valid, OR the scan results into the sticky flags, set draw if both bikes hit this scan, return to IDLE.
- rd_req is 0 in every state except ISSUE. rd_addr is don't-care when rd_req=0 but is driven to 0.
- Return pipeline: an RD_LAT-deep shift register of {valid, bike_id} tags, shifted every cycle. When a valid tag emerges, OR (rd_data != 0) into that bike's scan result.
- Grant stalls: ISSUE may stall any number of cycles; in-flight reads still complete normally.
- Game_State leaving 3'b010, in any state:
  - clear blue_hit, red_hit and draw on the next cycle;
  - abort to IDLE, with no hit_valid pulse;
  - in-flight tags are flushed (set invalid).
- Sticky flags persist across scans until Game_State leaves 3'b010 or Reset.
- Reset asserted mid-scan: immediate return to the reset state.

Decomposition:
- Shared package (tron_pkg):
  - direction encoding enum
  - GAME_PLAYING = 3'b010
  - probe offset constants (+8, +9, -9, +17, -2)
  - ROW_WORDS
  - address-width typedef
- Sub-module probe_addr_calc: combinational position/dir -> {addr, oob}, instanced once per bike.

Test Plan:
- Empty buffer, Blue (20,30) dir 10, Red (100,50) dir 01, rd_gnt=1 -> reads at 38474, 38794, 52696, 53016; hit_valid pulses once; blue_hit=0, red_hit=0.
- Same positions, memory word 38794 = 16'h0001 -> blue_hit=1, red_hit=0, draw=0; blue_hit stays 1 through the next clean scan.
- Blue (1,40) dir 11 -> blue OOB hit with no blue reads (only 2 red reads issued); Red (150,60) dir 10 (px=167) -> also OOB; zero reads total, hit_valid pulses, draw=1.
- rd_gnt low for 5 cycles, then toggling during ISSUE -> addresses issued in order exactly once each; results identical to the no-stall case.
- Game_State drops to 3'b000 while in DRAIN -> no hit_valid pulse, flags 0 the next cycle, FSM in IDLE; the next frame edge in state 3'b010 scans cleanly.
- Two frame_clk edges 3 cycles apart -> the second edge is ignored and only one hit_valid pulse occurs.
